// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-atomic arbiter sharing one UART transmitter among NUM_REQ byte streams.
// A grant is held until a last-marked byte or MAX_BURST bytes, then the pointer advances.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          grant_active,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                state_q, state_d;
    logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]        grant_id_q, grant_id_d;
    logic [CntW-1:0]       burst_cnt_q, burst_cnt_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

    logic                  slot_free;
    logic                  xfer;
    logic                  release_grant;
    logic                  pick_found;
    logic [IdW-1:0]        pick_id;
    logic [IdW-1:0]        scan_id;
    logic [DATA_WIDTH-1:0] sel_data;

    // The output register can take a byte when empty or when it drains this cycle.
    assign slot_free     = !tx_valid_q || tx_ready;
    assign sel_data      = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    assign xfer          = (state_q == StLocked) && req_valid[grant_id_q] && slot_free;
    assign release_grant = xfer &&
                           (req_last[grant_id_q] || (burst_cnt_q == CntW'(MAX_BURST - 1)));

    always_comb begin
        req_ready = '0;
        if (state_q == StLocked) begin
            req_ready[grant_id_q] = slot_free;
        end
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_id    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_id = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[scan_id]) begin
                pick_found = 1'b1;
                pick_id    = scan_id;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;

        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end
        if (xfer) begin
            tx_valid_d = 1'b1;
            tx_data_d  = sel_data;
        end

        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d     = StLocked;
                    grant_id_d  = pick_id;
                    burst_cnt_d = '0;
                end
            end
            StLocked: begin
                if (release_grant) begin
                    state_d     = StIdle;
                    burst_cnt_d = '0;
                    rr_ptr_d    = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign tx_valid     = tx_valid_q;
    assign tx_data      = tx_data_q;
    assign grant_active = (state_q == StLocked);
    assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-queue requesters, a UART-ready model and a scoreboard
// monitor that checks every accepted byte against the expected transmit order.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int SrcDepth = 64;

    logic             clock;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             grant_active;
    logic [1:0]       grant_id;

    uart_tx_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .MAX_BURST (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .grant_active(grant_active),
        .grant_id    (grant_id)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [8:0] src_mem [NR][SrcDepth];
    int         src_head [NR] = '{default: 0};
    int         src_tail [NR] = '{default: 0};
    int         flush_req = 0;
    int         flush_ack = 0;
    logic       pace = 1'b0;
    int         drain_load_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_src(input int r, input logic [7:0] d, input logic l);
        src_mem[r][src_tail[r]] = {l, d};
        src_tail[r]++;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d bytes pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        flush_req++;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Requester model: presents queue heads, pops after an observed handshake.
    initial begin
        logic [NR-1:0] fire;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clock);
            fire = req_valid & req_ready;
            @(posedge clock);
            #1;
            for (int i = 0; i < NR; i++) if (fire[i]) src_head[i]++;
            if (flush_ack != flush_req) begin
                for (int i = 0; i < NR; i++) src_head[i] = src_tail[i];
                flush_ack = flush_req;
            end
            for (int i = 0; i < NR; i++) begin
                if (src_head[i] < src_tail[i]) begin
                    req_valid[i]         = 1'b1;
                    req_data[i*DW +: DW] = src_mem[i][src_head[i]][7:0];
                    req_last[i]          = src_mem[i][src_head[i]][8];
                end else begin
                    req_valid[i]         = 1'b0;
                    req_data[i*DW +: DW] = '0;
                    req_last[i]          = 1'b0;
                end
            end
        end
    end

    // UART core model: always ready, or one cycle in ten when pacing.
    initial begin
        int pc;
        pc = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            pc = (pc + 1) % 10;
            tx_ready = pace ? (pc == 0) : 1'b1;
        end
    end

    // Scoreboard monitor.
    initial begin
        logic       stall_seen;
        logic [7:0] stall_data;
        logic [7:0] e;
        stall_seen = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall_seen = 1'b0;
            end else begin
                if (stall_seen && tx_valid) begin
                    n_tests++;
                    if (tx_data !== stall_data) begin
                        n_fail++;
                        $display("FAIL tx_hold: got 0x%02h, required 0x%02h", tx_data, stall_data);
                    end
                end
                if (tx_valid && tx_ready) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL tx_extra: got 0x%02h, required no byte", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (tx_data !== e) begin
                            n_fail++;
                            $display("FAIL tx_byte: got 0x%02h, required 0x%02h", tx_data, e);
                        end
                    end
                    if (grant_active && req_valid[grant_id] && req_ready[grant_id])
                        drain_load_cnt++;
                end
                stall_seen = tx_valid && !tx_ready;
                stall_data = tx_data;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dl0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_grant", 32'({grant_active, grant_id}), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single requester, no contention.
        push_src(1, 8'h41, 1'b0);
        push_src(1, 8'h42, 1'b0);
        push_src(1, 8'h43, 1'b1);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        @(negedge clock);
        chk("single_arb_cycle", 32'(grant_active), 32'd0);
        @(negedge clock);
        chk("single_grant", 32'({grant_active, grant_id}), 32'({1'b1, 2'd1}));
        chk("single_ready", 32'(req_ready), 32'b0010);
        repeat (2) begin
            @(negedge clock);
            chk("single_held", 32'(grant_active), 32'd1);
        end
        @(negedge clock);
        chk("single_release", 32'(grant_active), 32'd0);
        wait_drain("single");

        // Round-robin order from a fresh pointer.
        pulse_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR; i++) begin
                push_src(i, 8'hA0 + 8'(i), 1'b1);
                exp_q.push_back(8'hA0 + 8'(i));
            end
        end
        @(negedge clock);
        chk("rr_arb_cycle", 32'(grant_active), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk("rr_grant", 32'({grant_active, grant_id}), 32'({1'b1, 2'(k % NR)}));
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % NR)));
            @(negedge clock);
            chk("rr_idle_gap", 32'(grant_active), 32'd0);
        end
        wait_drain("rr");

        // Frame atomicity.
        pulse_reset();
        for (int b = 0; b < 4; b++) begin
            push_src(0, 8'h10 + 8'(b), b == 3);
            exp_q.push_back(8'h10 + 8'(b));
        end
        push_src(2, 8'h55, 1'b1);
        exp_q.push_back(8'h55);
        @(negedge clock);
        repeat (4) begin
            @(negedge clock);
            chk("atom_grant", 32'({grant_active, grant_id}), 32'({1'b1, 2'd0}));
            chk("atom_ready2", 32'(req_ready[2]), 32'd0);
        end
        wait_drain("atom");

        // Forced release after MAX_BURST bytes.
        pulse_reset();
        for (int b = 0; b < 20; b++) push_src(3, 8'(b), 1'b0);
        for (int b = 0; b < 16; b++) exp_q.push_back(8'(b));
        exp_q.push_back(8'h77);
        for (int b = 16; b < 20; b++) exp_q.push_back(8'(b));
        repeat (3) @(negedge clock);
        push_src(0, 8'h77, 1'b1);
        wait_drain("burst");
        repeat (5) @(negedge clock);
        chk("burst_hold_grant", 32'({grant_active, grant_id}), 32'({1'b1, 2'd3}));

        // UART-paced backpressure.
        pulse_reset();
        pace = 1'b1;
        dl0 = drain_load_cnt;
        for (int b = 0; b < 5; b++) begin
            push_src(2, 8'hAC + 8'(b), b == 4);
            exp_q.push_back(8'hAC + 8'(b));
        end
        wait_drain("pace");
        repeat (30) @(negedge clock);
        chk("pace_drain_load", 32'(drain_load_cnt > dl0), 32'd1);
        chk("pace_tx_empty", 32'(tx_valid), 32'd0);
        pace = 1'b0;

        // Reset mid-frame.
        pulse_reset();
        for (int b = 0; b < 4; b++) push_src(1, 8'h21 + 8'(b), b == 3);
        @(negedge clock);
        @(negedge clock);
        @(posedge clock);
        #3;
        reset = 1'b1;
        flush_req++;
        @(posedge clock);
        #3;
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
        chk("mid_rst_grant", 32'({grant_active, grant_id}), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        push_src(0, 8'h30, 1'b1);
        push_src(1, 8'h31, 1'b1);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h31);
        @(negedge clock);
        @(negedge clock);
        chk("mid_rst_first", 32'({grant_active, grant_id}), 32'({1'b1, 2'd0}));
        wait_drain("mid_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (serial_tx path of top) between NUM_REQ byte-stream requesters, e.g. echo path, status reporter and debug dump.
- Grants are round-robin and frame-atomic: once granted, a requester holds the transmitter until it sends a byte marked last, or until MAX_BURST bytes have gone out.
- Sits between the requesters and the uart_tx core; presents one valid/ready byte stream to the core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width on every port.
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255).

Ports:
- clock  input  1  system clock (20 ns period; UART bit = 10 clocks).
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*DATA_WIDTH  per-requester byte; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  marks the final byte of requester's frame.
- req_ready  output  NUM_REQ  per-requester byte accepted (transfer = valid & ready).
- tx_data  output  DATA_WIDTH  byte to uart_tx core.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  uart_tx core accepts byte (high only when core idle).
- grant_active  output  1  a requester currently holds the grant.
- grant_id  output  $clog2(NUM_REQ)  index of holder; valid only when grant_active.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - tx_valid=0, tx_data=0, grant_active=0, grant_id=0, req_ready=0.
  - rr_ptr=0, burst_cnt=0, state=IDLE.
- Reset mid-frame discards any buffered byte and the grant. No partial frame resumes.
- State machine:
  - Two states, IDLE and LOCKED, all registered.
  - IDLE: if any req_valid is high, select the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Next cycle: state=LOCKED, grant_active=1, grant_id=i, burst_cnt=0.
  - IDLE with no req_valid: remain IDLE.
  - Arbitration costs exactly one cycle. The earliest transfer is the cycle after the first req_valid.
  - LOCKED: req_ready[grant_id] = !tx_valid | tx_ready. All other req_ready bits are 0. req_ready is combinational from registered state and tx_ready only; it never depends on req_valid.
  - A transfer loads req_data into the tx register, sets tx_valid=1 and increments burst_cnt.
  - Release condition: a transfer with req_last=1, or a transfer with burst_cnt==MAX_BURST-1.
  - On release: next cycle state=IDLE, grant_active=0, rr_ptr=(grant_id+1) mod NUM_REQ, burst_cnt=0.
  - Granted requester dropping req_valid mid-frame: grant is held indefinitely; no timeout.
- Output register (single entry):
  - tx_valid clears when tx_valid & tx_ready and no load occurs in the same cycle.
  - Simultaneous drain and load keeps tx_valid=1 with the new byte. No byte is lost or duplicated.
  - tx_data holds its value while tx_valid & !tx_ready.
  - After release, a buffered byte still drains normally in IDLE.
- Bytes of different grants are never interleaved on tx_data.
- Requesters not granted see req_ready=0 regardless of their req_valid.
- Fairness:
  - A requester continuously valid is granted within NUM_REQ-1 other grants.
  - Each grant delivers at most MAX_BURST bytes.
- Widths: burst_cnt is $clog2(MAX_BURST+1) bits. The rr_ptr increment wraps NUM_REQ-1 -> 0.

Test Plan:
- Single requester, no contention:
  - Stimulus: after reset, req 1 sends 0x41,0x42,0x43 (last on 0x43); tx_ready=1 always.
  - Required: grant_active/grant_id=1 one cycle after req_valid; tx_data sequence 0x41,0x42,0x43; grant_active drops the cycle after the 0x43 transfer.
- Round-robin order:
  - Stimulus: all 4 requesters continuously valid with single-byte frames (last=1), data 0xA0+i.
  - Required: tx order 0xA0,0xA1,0xA2,0xA3,0xA0; each grant separated by one IDLE cycle.
- Frame atomicity:
  - Stimulus: req 0 sends 4-byte frame 0x10..0x13 while req 2 holds req_valid with 0x55.
  - Required: 0x10..0x13 contiguous on tx_data, then 0x55; req_ready[2]=0 throughout req 0's grant.
- Forced release:
  - Stimulus: req 3 streams 20 bytes 0x00..0x13 with req_last=0; req 0 also valid.
  - Required: release after byte 0x0F (16 bytes); req 0 granted next; req 3 regranted later and resumes at 0x10.
- UART-paced backpressure:
  - Stimulus: tx_ready pulses high 1 cycle in 10; req 2 sends 0xAC..0xB0.
  - Required: exactly 5 bytes emitted in order, each held stable while stalled; drain and load in the same cycle verified.
- Reset mid-frame:
  - Stimulus: assert reset during the 2nd byte of a 4-byte frame from req 1.
  - Required: next cycle all outputs 0 and rr_ptr=0; a subsequent request from req 0 and req 1 grants req 0 first.
